add_base_pipe: RTL

// - Pipelined multi-operand adder: the device-side counterpart of the Add_base stimulus/check bench.
// - Accepts NUMBER_INPUT packed unsigned operands per cycle and returns their sum, one result per cycle.
// - The long carry chain is split across two stages so the block closes at the gate-level cycle of 26.5625 ns.
// - Adds in_valid/out_valid qualification, an overflow flag and a result counter for bench bookkeeping.

---
 rtl/add_base_pipe_if.sv | 27 ++
 rtl/add_base_pipe.sv | 127 ++++++++++++
 2 files changed

// File: rtl/add_base_pipe_if.sv
// Operand/result bundle for the pipelined multi-operand adder.
// Valid semantics: in_valid qualifies in for exactly the cycle it is high.
// There is no ready; the adder accepts every valid set. out_valid qualifies
// out/out_ovf for one cycle, and out/out_ovf hold their value between pulses.
interface add_base_pipe_if #(
  parameter int NUMBER_INPUT = 3,
  parameter int BIT_INPUT    = 28,
  parameter int BIT_OUTPUT   = 29,
  parameter int CNT_W        = 16
);
  logic                              in_valid;
  logic [NUMBER_INPUT*BIT_INPUT-1:0] in;
  logic                              out_valid;
  logic [BIT_OUTPUT-1:0]             out;
  logic                              out_ovf;
  logic [CNT_W-1:0]                  out_cnt;

  modport master (
    output in_valid, in,
    input  out_valid, out, out_ovf, out_cnt
  );

  modport slave (
    input  in_valid, in,
    output out_valid, out, out_ovf, out_cnt
  );
endinterface

// File: rtl/add_base_pipe.sv
// Three-stage pipelined adder for NUMBER_INPUT unsigned operands.
// S1 registers the operands. S2 compresses them carry-save and adds the low
// half. S3 finishes the high half and flags overflow. The carry chain is split
// at LO_W so that no stage carries a full-width add.
module add_base_pipe #(
  parameter int NUMBER_INPUT = 3,
  parameter int BIT_INPUT    = 28,
  parameter int BIT_OUTPUT   = 29,
  parameter int CNT_W        = 16
) (
  input logic            clk,
  input logic            rst_n,
  add_base_pipe_if.slave bus
);
  localparam int WF    = BIT_INPUT + $clog2(NUMBER_INPUT);
  localparam int LO_W  = WF / 2;
  localparam int HI_W  = WF - LO_W;
  localparam int EXT_W = (WF > BIT_OUTPUT) ? WF : BIT_OUTPUT;
  localparam int OPS_W = NUMBER_INPUT * BIT_INPUT;

  // Stage S1 state
  logic             r_v1;
  logic [OPS_W-1:0] r_ops;
  // Stage S2 state
  logic             r_v2;
  logic [LO_W-1:0]  r_lo;
  logic             r_clo;
  logic [HI_W-1:0]  r_s_hi;
  logic [HI_W-1:0]  r_c_hi;
  // Stage S3 / output state
  logic                  r_out_valid;
  logic [BIT_OUTPUT-1:0] r_out;
  logic                  r_ovf;
  logic [CNT_W-1:0]      r_cnt;

  logic [WF-1:0]    w_s;
  logic [WF-1:0]    w_c;
  logic [WF-1:0]    w_x;
  logic [WF-1:0]    w_maj;
  logic [LO_W:0]    w_lo_sum;
  logic [HI_W-1:0]  w_high;
  logic [WF-1:0]    w_full;
  logic [EXT_W-1:0] w_full_ext;
  logic             w_ovf;

  // S1: capture operands only when qualified so idle X never enters the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_ops <= '0;
    end else begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) r_ops <= bus.in;
    end
  end

  // Carry-save compression of all operands to one sum and one carry vector
  always_comb begin
    w_x   = '0;
    w_maj = '0;
    w_s   = WF'(r_ops[0 +: BIT_INPUT]);
    w_c   = WF'(r_ops[BIT_INPUT +: BIT_INPUT]);
    for (int j = 2; j < NUMBER_INPUT; j++) begin
      w_x   = WF'(r_ops[j*BIT_INPUT +: BIT_INPUT]);
      w_maj = (w_s & w_c) | (w_s & w_x) | (w_c & w_x);
      w_s   = w_s ^ w_c ^ w_x;
      w_c   = w_maj << 1;
    end
  end

  // Low-half add; its carry-out is handed to S3
  assign w_lo_sum = {1'b0, w_s[LO_W-1:0]} + {1'b0, w_c[LO_W-1:0]};

  // S2: register the low result, its carry and both high halves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_lo   <= '0;
      r_clo  <= 1'b0;
      r_s_hi <= '0;
      r_c_hi <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_lo   <= w_lo_sum[LO_W-1:0];
        r_clo  <= w_lo_sum[LO_W];
        r_s_hi <= w_s[WF-1:LO_W];
        r_c_hi <= w_c[WF-1:LO_W];
      end
    end
  end

  // High-half add; the full sum fits WF bits, so truncation here is exact
  assign w_high     = r_s_hi + r_c_hi + HI_W'(r_clo);
  assign w_full     = {w_high, r_lo};
  assign w_full_ext = EXT_W'(w_full);

  generate
    if (WF > BIT_OUTPUT) begin : g_ovf
      assign w_ovf = |w_full[WF-1:BIT_OUTPUT];
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate

  // S3: issue the result, and hold out/out_ovf on bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_out <= w_full_ext[BIT_OUTPUT-1:0];
        r_ovf <= w_ovf;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_cnt   = r_cnt;
endmodule
